// File: rtl/data_lsu.sv
// Load-store unit: turns core byte/half/word accesses into word-wide memory
// requests with byte enables, then extends the returned load data for the core.
module data_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_we;
    logic [2:0]      r_size;
    logic [1:0]      r_addr_lo;
    logic [3:0]      r_be;
    logic [31:0]     r_addr;
    logic [31:0]     r_wd;
    logic [31:0]     r_cnt;

    logic            w_illegal;
    logic            w_issue;
    logic            w_timeout;
    logic [3:0]      w_be;
    logic [31:0]     w_wd;
    logic [3:0][7:0] w_lane;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = mem_rd_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        w_illegal = 1'b0;
        case (core_size_i)
            3'd0, 3'd4: w_illegal = 1'b0;
            3'd1, 3'd5: w_illegal = core_addr_i[0];
            3'd2:       w_illegal = (core_addr_i[1:0] != 2'b00);
            default:    w_illegal = 1'b1;
        endcase
    end

    assign w_issue   = core_req_i && !w_illegal;
    // r_cnt holds the number of WAIT cycles already completed, so the abort
    // fires on the TIMEOUT_CYCLES-th WAIT cycle.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && !mem_ready_i &&
                       (r_cnt == TIMEOUT_CYCLES - 1);

    // Store data is replicated across lanes so the memory only needs the byte enables.
    always_comb begin
        w_be = 4'b1111;
        w_wd = '0;
        if (core_we_i) begin
            case (core_size_i[1:0])
                2'd0: begin
                    w_be = 4'b0001 << core_addr_i[1:0];
                    w_wd = {4{core_wd_i[7:0]}};
                end
                2'd1: begin
                    w_be = 4'b0011 << core_addr_i[1:0];
                    w_wd = {2{core_wd_i[15:0]}};
                end
                default: begin
                    w_be = 4'b1111;
                    w_wd = core_wd_i;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = w_lane[r_addr_lo];
        w_half = r_addr_lo[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (r_size)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd4:    w_load = {24'd0, w_byte};
            3'd5:    w_load = {16'd0, w_half};
            default: w_load = mem_rd_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_size    <= '0;
            r_addr_lo <= '0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wd      <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (r_state == ST_WAIT) ? r_cnt + 32'd1 : 32'd0;
            if (r_state == ST_IDLE && w_issue) begin
                r_we      <= core_we_i;
                r_size    <= core_size_i;
                r_addr_lo <= core_addr_i[1:0];
                r_be      <= w_be;
                r_addr    <= {core_addr_i[31:2], 2'b00};
                r_wd      <= w_wd;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_issue) w_state_next = mem_ready_i ? ST_DONE : ST_WAIT;
            ST_WAIT: begin
                if (mem_ready_i)    w_state_next = ST_DONE;
                else if (w_timeout) w_state_next = ST_IDLE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        core_rd_o    = '0;
        core_stall_o = 1'b0;
        core_err_o   = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        mem_addr_o   = '0;
        mem_wd_o     = '0;
        if (!rst_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (core_req_i && w_illegal) begin
                        core_err_o = 1'b1;
                    end else if (core_req_i) begin
                        mem_req_o    = 1'b1;
                        core_stall_o = 1'b1;
                        mem_we_o     = core_we_i;
                        mem_be_o     = w_be;
                        mem_addr_o   = {core_addr_i[31:2], 2'b00};
                        mem_wd_o     = w_wd;
                    end
                end
                ST_WAIT: begin
                    if (w_timeout) begin
                        core_err_o = 1'b1;
                    end else begin
                        mem_req_o    = 1'b1;
                        core_stall_o = 1'b1;
                        mem_we_o     = r_we;
                        mem_be_o     = r_be;
                        mem_addr_o   = r_addr;
                        mem_wd_o     = r_wd;
                    end
                end
                ST_DONE: if (!r_we) core_rd_o = w_load;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_lsu.sv
// Randomized and directed bench for data_lsu against a byte-array memory
// reference model; the DUT runs with a 4-cycle WAIT timeout.
module tb_data_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_size = 3'd0;
    logic [31:0] core_addr = 32'd0;
    logic [31:0] core_wd = 32'd0;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd = 32'd0;
    logic        mem_ready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  ref_mem    [256];
    logic [31:0] init_words [64];
    logic [31:0] env_mem    [64];
    logic        load_mem = 1'b0;

    always #5 clk = ~clk;

    data_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .core_err_o   (core_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd),
        .mem_ready_i  (mem_ready)
    );

    // Word memory environment: read data registered one cycle after acceptance,
    // garbage on every other cycle.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= init_words[i];
        end else if (mem_req_o && mem_ready) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) env_mem[mem_addr_o[7:2]][8*b +: 8] <= mem_wd_o[8*b +: 8];
            end else begin
                mem_rd <= env_mem[mem_addr_o[7:2]];
            end
        end else begin
            mem_rd <= $urandom;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] outs_or();
        return core_rd_o | mem_addr_o | mem_wd_o | {28'd0, mem_be_o} |
               {28'd0, core_stall_o, core_err_o, mem_req_o, mem_we_o};
    endfunction

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] sz, input int a);
        longint v = 0;
        int n = nbytes(sz);
        for (int k = 0; k < n; k++) v += longint'(ref_mem[a + k]) << (8 * k);
        if ((sz == 3'd0 || sz == 3'd1) && v >= (longint'(1) << (8 * n - 1)))
            v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int nlow);
        logic [31:0] ebe, ewd, erd, waddr;
        int n, lo, cyc;
        n = nbytes(sz);
        lo = int'(a[1:0]);
        ebe = 0;
        ewd = 0;
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= lo && i < lo + n) ebe[i] = 1'b1;
                ewd[8*i +: 8] = wd[8*(i % n) +: 8];
            end
        end else begin
            ebe = 32'hf;
        end
        erd = we ? 32'd0 : ref_load(sz, int'(a[7:0]));
        waddr = {a[31:2], 2'b00};

        @(negedge clk);
        core_req = 1'b1; core_we = we; core_size = sz; core_addr = a; core_wd = wd;
        mem_ready = (nlow == 0);
        #1;
        chk("issue_req", {31'd0, mem_req_o}, 32'd1);
        chk("issue_stall", {31'd0, core_stall_o}, 32'd1);
        chk("issue_err", {31'd0, core_err_o}, 32'd0);
        chk("issue_we", {31'd0, mem_we_o}, {31'd0, we});
        chk("issue_be", {28'd0, mem_be_o}, ebe);
        chk("issue_addr", mem_addr_o, waddr);
        chk("issue_wd", mem_wd_o, ewd);
        chk("issue_rd", core_rd_o, 32'd0);
        cyc = 0;
        while (cyc < nlow) begin
            @(negedge clk);
            cyc++;
            mem_ready = (cyc >= nlow);
            #1;
            chk("wait_req", {31'd0, mem_req_o}, 32'd1);
            chk("wait_stall", {31'd0, core_stall_o}, 32'd1);
            chk("wait_addr", mem_addr_o, waddr);
            chk("wait_be", {28'd0, mem_be_o}, ebe);
            chk("wait_wd", mem_wd_o, ewd);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("done_req", {31'd0, mem_req_o}, 32'd0);
        chk("done_stall", {31'd0, core_stall_o}, 32'd0);
        chk("done_err", {31'd0, core_err_o}, 32'd0);
        chk("done_rd", core_rd_o, erd);
        core_req = 1'b0;
        if (we) for (int k = 0; k < n; k++) ref_mem[int'(a[7:0]) + k] = wd[8*k +: 8];
        $display("txn we=%0d size=%0d addr=%08h wd=%08h low=%0d rd=%08h", we, sz, a, wd, nlow, core_rd_o);
    endtask

    task automatic illegal(input logic we, input logic [2:0] sz, input logic [31:0] a);
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_size = sz; core_addr = a; core_wd = $urandom;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        chk("ill_err", {31'd0, core_err_o}, 32'd1);
        chk("ill_req", {31'd0, mem_req_o}, 32'd0);
        chk("ill_stall", {31'd0, core_stall_o}, 32'd0);
        @(negedge clk);
        core_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk("ill_after_idle", outs_or(), 32'd0);
        $display("txn illegal we=%0d size=%0d addr=%08h", we, sz, a);
    endtask

    task automatic timeout_run();
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h20; mem_ready = 1'b0;
        #1;
        chk("to_issue_req", {31'd0, mem_req_o}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            chk("to_err", {31'd0, core_err_o}, (k == 4) ? 32'd1 : 32'd0);
            chk("to_req", {31'd0, mem_req_o}, (k == 4) ? 32'd0 : 32'd1);
            chk("to_stall", {31'd0, core_stall_o}, (k == 4) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        core_req = 1'b0;
        #1;
        chk("to_after_idle", outs_or(), 32'd0);
        $display("txn timeout LW addr=00000020");
    endtask

    task automatic reset_mid(input logic in_done);
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h20; mem_ready = in_done;
        #1;
        chk("rst_issue_req", {31'd0, mem_req_o}, 32'd1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("rst_pre_stall", {31'd0, core_stall_o}, in_done ? 32'd0 : 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_held_zero", outs_or(), 32'd0);
        @(negedge clk);
        rst = 1'b0; core_req = 1'b0;
        #1;
        chk("rst_after_idle", outs_or(), 32'd0);
        $display("txn reset during %s", in_done ? "DONE" : "WAIT");
    endtask

    initial begin
        logic [31:0] w, a;
        logic [2:0]  sz;
        logic        we;
        logic [2:0]  szt [5];
        szt = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            init_words[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        rst = 1'b1; load_mem = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h20; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs_zero", outs_or(), 32'd0);
        load_mem = 1'b0; core_req = 1'b0; mem_ready = 1'b0; rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_outputs_zero", outs_or(), 32'd0);

        access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        access(1'b1, 3'd0, 32'h13, 32'h000000A5, 0);
        access(1'b1, 3'd1, 32'h12, 32'h00001234, 0);
        access(1'b1, 3'd2, 32'h20, 32'h80FF7F01, 0);
        access(1'b0, 3'd0, 32'h21, 32'd0, 0);
        access(1'b0, 3'd0, 32'h23, 32'd0, 0);
        access(1'b0, 3'd4, 32'h22, 32'd0, 0);
        access(1'b0, 3'd1, 32'h22, 32'd0, 0);
        access(1'b0, 3'd5, 32'h22, 32'd0, 0);
        access(1'b0, 3'd2, 32'h20, 32'd0, 0);
        access(1'b0, 3'd2, 32'h20, 32'd0, 3);
        access(1'b0, 3'd2, 32'h10, 32'd0, 1);

        illegal(1'b0, 3'd1, 32'h01);
        illegal(1'b1, 3'd2, 32'h06);
        illegal(1'b0, 3'd3, 32'h20);
        illegal(1'b1, 3'd6, 32'h00);
        illegal(1'b0, 3'd7, 32'h00);
        illegal(1'b0, 3'd5, 32'h23);
        illegal(1'b0, 3'd2, 32'h22);

        timeout_run();
        reset_mid(1'b0);
        reset_mid(1'b1);
        access(1'b0, 3'd2, 32'h20, 32'd0, 2);

        for (int t = 0; t < 80; t++) begin
            we = 1'($urandom_range(0, 1));
            sz = we ? 3'($urandom_range(0, 2)) : szt[$urandom_range(0, 4)];
            a = 32'($urandom_range(0, 255));
            if (nbytes(sz) == 2) a[0] = 1'b0;
            if (nbytes(sz) == 4) a[1:0] = 2'b00;
            access(we, sz, a, $urandom, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
